// File: rtl/gsim_result_sink_if.sv
// Handshake bundle between the Gauss-Seidel solver, gsim_result_sink and its downstream consumer.
// The `converged` signal exists only when GSIM_SINK_CONVERGE_EN is defined.
interface gsim_result_sink_if #(
  parameter int IN_W  = 32,
  parameter int OUT_W = 16
);
  logic             in_valid;
  logic [IN_W-1:0]  in_data;
  logic             out_valid;
  logic             out_ready;
  logic [OUT_W-1:0] out_data;
  logic             out_first;
  logic             out_last;
  logic             frame_err;
  logic             busy;
`ifdef GSIM_SINK_CONVERGE_EN
  logic             converged;
`endif

  // master is the environment (solver plus consumer); slave is the sink itself
  modport master (
    output in_valid, in_data, out_ready,
    input  out_valid, out_data, out_first, out_last, frame_err, busy
`ifdef GSIM_SINK_CONVERGE_EN
    , input converged
`endif
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output out_valid, out_data, out_first, out_last, frame_err, busy
`ifdef GSIM_SINK_CONVERGE_EN
    , output converged
`endif
  );
endinterface

// File: rtl/gsim_result_sink.sv
// Captures a Q16.16 solution frame, converts each word to a rounded/saturated integer and drains it
// over valid/ready. Optional GSIM_SINK_CONVERGE_EN adds frame-to-frame convergence detection.
module gsim_result_sink #(
  parameter int N_WORDS = 16,
  parameter int IN_W    = 32,
  parameter int OUT_W   = 16
`ifdef GSIM_SINK_CONVERGE_EN
  , parameter int TOL   = 1
`endif
) (
  input logic               clk,
  input logic               reset,
  gsim_result_sink_if.slave bus
);

  localparam int               IDX_W    = $clog2(N_WORDS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_WORDS - 1);
  localparam int               FRAC_W   = IN_W - OUT_W;

  typedef enum logic [1:0] {IDLE, CAPTURE, DRAIN} state_t;

  state_t           state_q;
  logic [IDX_W-1:0] wrIdx_q;
  logic [IDX_W-1:0] rdIdx_q;
  logic [IDX_W-1:0] rdIdx_d;
  logic [IDX_W-1:0] wrAddr;
  logic             captureLast;
  logic             outValid_q;
  logic [OUT_W-1:0] outData_q;
  logic             outFirst_q;
  logic             outLast_q;
  logic             frameErr_q;
  logic             overrunSeen_q;
  logic [OUT_W-1:0] wordBuf_q [N_WORDS];

  logic [OUT_W:0]   rounded;
  logic [OUT_W-1:0] convWord_d;
  logic             unusedFracBits;

  // Round half up on the integer part, then clamp the 17-bit sum back into 16 signed bits
  always_comb begin
    rounded = {bus.in_data[IN_W-1], bus.in_data[IN_W-1 -: OUT_W]}
            + {{OUT_W{1'b0}}, bus.in_data[FRAC_W-1]};
    if (!rounded[OUT_W] && rounded[OUT_W-1]) begin
      convWord_d = {1'b0, {(OUT_W-1){1'b1}}};
    end else if (rounded[OUT_W] && !rounded[OUT_W-1]) begin
      convWord_d = {1'b1, {(OUT_W-1){1'b0}}};
    end else begin
      convWord_d = rounded[OUT_W-1:0];
    end
  end

  assign unusedFracBits = ^bus.in_data[FRAC_W-2:0];
  assign wrAddr         = (state_q == CAPTURE) ? wrIdx_q : '0;
  assign rdIdx_d        = rdIdx_q + 1'b1;
  assign captureLast    = (state_q == CAPTURE) && bus.in_valid && (wrIdx_q == LAST_IDX);

  always_ff @(posedge clk) begin
    if (bus.in_valid && (state_q != DRAIN)) begin
      wordBuf_q[wrAddr] <= convWord_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q       <= IDLE;
      wrIdx_q       <= '0;
      rdIdx_q       <= '0;
      outValid_q    <= 1'b0;
      outData_q     <= '0;
      outFirst_q    <= 1'b0;
      outLast_q     <= 1'b0;
      frameErr_q    <= 1'b0;
      overrunSeen_q <= 1'b0;
    end else begin
      frameErr_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (bus.in_valid) begin
            wrIdx_q <= IDX_W'(1);
            state_q <= CAPTURE;
          end
        end
        CAPTURE: begin
          if (!bus.in_valid) begin
            frameErr_q <= 1'b1;
            wrIdx_q    <= '0;
            state_q    <= IDLE;
          end else if (captureLast) begin
            state_q       <= DRAIN;
            wrIdx_q       <= '0;
            rdIdx_q       <= '0;
            outValid_q    <= 1'b1;
            outData_q     <= wordBuf_q[0];
            outFirst_q    <= 1'b1;
            outLast_q     <= (LAST_IDX == '0);
            overrunSeen_q <= 1'b0;
          end else begin
            wrIdx_q <= wrIdx_q + 1'b1;
          end
        end
        DRAIN: begin
          // Words arriving while draining are dropped; only the first one of a drain raises the error
          if (bus.in_valid && !overrunSeen_q) begin
            frameErr_q    <= 1'b1;
            overrunSeen_q <= 1'b1;
          end
          if (bus.out_ready) begin
            if (rdIdx_q == LAST_IDX) begin
              outValid_q <= 1'b0;
              outData_q  <= '0;
              outFirst_q <= 1'b0;
              outLast_q  <= 1'b0;
              rdIdx_q    <= '0;
              state_q    <= IDLE;
            end else begin
              rdIdx_q    <= rdIdx_d;
              outData_q  <= wordBuf_q[rdIdx_d];
              outFirst_q <= 1'b0;
              outLast_q  <= (rdIdx_d == LAST_IDX);
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.out_valid = outValid_q;
  assign bus.out_data  = outData_q;
  assign bus.out_first = outFirst_q;
  assign bus.out_last  = outLast_q;
  assign bus.frame_err = frameErr_q;
  assign bus.busy      = (state_q != IDLE);

`ifdef GSIM_SINK_CONVERGE_EN
  localparam logic [OUT_W:0] TOL_V = (OUT_W + 1)'(TOL);

  logic [OUT_W-1:0] prevBuf_q [N_WORDS];
  logic             prevValid_q;
  logic             withinTol_q;
  logic             withinTol_d;
  logic             converged_q;
  logic [OUT_W:0]   diff;
  logic [OUT_W:0]   absDiff;

  // Running "every word so far within TOL of last frame" flag; the first word of a frame restarts it
  always_comb begin
    diff        = {convWord_d[OUT_W-1], convWord_d}
                - {prevBuf_q[wrAddr][OUT_W-1], prevBuf_q[wrAddr]};
    absDiff     = diff[OUT_W] ? (~diff + 1'b1) : diff;
    withinTol_d = (absDiff <= TOL_V) && ((state_q == IDLE) ? 1'b1 : withinTol_q);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      prevValid_q <= 1'b0;
      withinTol_q <= 1'b0;
      converged_q <= 1'b0;
    end else if (bus.in_valid && (state_q != DRAIN)) begin
      withinTol_q <= withinTol_d;
      if (captureLast) begin
        converged_q <= withinTol_d && prevValid_q;
        prevValid_q <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (captureLast) begin
      for (int i = 0; i < N_WORDS; i++) begin
        prevBuf_q[i] <= (i == N_WORDS - 1) ? convWord_d : wordBuf_q[i];
      end
    end
  end

  assign bus.converged = converged_q;
`endif

endmodule

// File: tb/tb_gsim_result_sink.sv
// Self-checking bench for gsim_result_sink: conversion table, burst latency, backpressure,
// short frame, overrun and mid-drain reset; convergence frames when GSIM_SINK_CONVERGE_EN is defined.
module tb_gsim_result_sink;
  localparam int N = 16;

  typedef struct {
    logic [31:0] inData;
    logic [15:0] expOut;
  } vec_t;

  typedef struct {
    logic [15:0] data;
    logic        first;
    logic        last;
  } exp_t;

  logic clk   = 1'b0;
  logic reset = 1'b0;

  gsim_result_sink_if #(.IN_W(32), .OUT_W(16)) bus ();

  gsim_result_sink #(.N_WORDS(N), .IN_W(32), .OUT_W(16)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int          errors = 0;
  int          checks = 0;
  exp_t        expQ[$];
  exp_t        monE;
  vec_t        vecs[N];
  logic [31:0] frameWords[N];
  bit          readyMode  = 1'b0;
  logic        readyForce = 1'b1;
  bit          prevStall  = 1'b0;
  logic [15:0] prevData;
  logic        prevFirst;
  logic        prevLast;
  logic        prevErr    = 1'b0;
  int          errEdges   = 0;
  int          errHigh    = 0;
  bit          sawValid   = 1'b0;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  function automatic logic [15:0] modelConv(input logic [31:0] x);
    int r;
    r = int'($signed(x[31:16])) + int'(x[15]);
    if (r > 32767) r = 32767;
    else if (r < -32768) r = -32768;
    return 16'(r);
  endfunction

  task automatic applyStimulus(input int count, input bit pushExp);
    for (int k = 0; k < count; k++) begin
      @(posedge clk); #1;
      bus.in_valid = 1'b1;
      bus.in_data  = frameWords[k];
      if (pushExp) expQ.push_back('{data: modelConv(frameWords[k]), first: (k == 0), last: (k == N - 1)});
    end
  endtask

  task automatic idleInputs();
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
  endtask

  task automatic waitDrain(input string name);
    bit done = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (expQ.size() == 0 && !bus.out_valid) begin
        done = 1'b1;
        break;
      end
    end
    checks++;
    if (!done) begin
      errors++;
      $display("[TB] FAIL %s: drain timeout, pending=%0d, expected 0", name, expQ.size());
    end
  endtask

  // Ready pattern 1,0,0,1 repeating when readyMode is set, otherwise a constant level
  initial begin
    int cyc = 0;
    bus.out_ready = 1'b0;
    forever begin
      @(posedge clk); #1;
      cyc++;
      if (readyMode) bus.out_ready = ((cyc % 4) == 0) || ((cyc % 4) == 3);
      else           bus.out_ready = readyForce;
    end
  end

  // Scoreboard pop, stall-stability check and frame_err pulse bookkeeping
  always @(negedge clk) begin
    if (!reset) begin
      prevStall = 1'b0;
      prevErr   = 1'b0;
    end else begin
      if (prevStall) begin
        checkOutput("stall_valid", 32'(bus.out_valid), 32'd1);
        checkOutput("stall_hold", 32'({bus.out_data, bus.out_first, bus.out_last}),
                    32'({prevData, prevFirst, prevLast}));
      end
      if (bus.out_valid) sawValid = 1'b1;
      if (bus.out_valid && bus.out_ready) begin
        if (expQ.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpected_word: got 0x%0h, expected no word", bus.out_data);
        end else begin
          monE = expQ.pop_front();
          checkOutput("out_data", 32'(bus.out_data), 32'(monE.data));
          checkOutput("out_flags", 32'({bus.out_first, bus.out_last}), 32'({monE.first, monE.last}));
        end
      end
      prevStall = bus.out_valid && !bus.out_ready;
      prevData  = bus.out_data;
      prevFirst = bus.out_first;
      prevLast  = bus.out_last;
      if (bus.frame_err) errHigh++;
      if (bus.frame_err && !prevErr) errEdges++;
      prevErr = bus.frame_err;
    end
  end

  initial begin
    #200000;
    errors++;
    $display("[TB] FAIL watchdog: simulation still running, expected completion");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    bit found;
    vecs[0]  = '{32'h0001_8000, 16'h0002};
    vecs[1]  = '{32'hFFFF_8000, 16'h0000};
    vecs[2]  = '{32'h7FFF_FFFF, 16'h7FFF};
    vecs[3]  = '{32'h8000_0000, 16'h8000};
    vecs[4]  = '{32'h0000_7FFF, 16'h0000};
    vecs[5]  = '{32'hFFFF_7FFF, 16'hFFFF};
    vecs[6]  = '{32'h0002_8000, 16'h0003};
    vecs[7]  = '{32'hFFFE_8000, 16'hFFFF};
    vecs[8]  = '{32'h7FFF_7FFF, 16'h7FFF};
    vecs[9]  = '{32'h8000_8000, 16'h8001};
    vecs[10] = '{32'h0000_8000, 16'h0001};
    vecs[11] = '{32'hFFFF_FFFF, 16'h0000};
    vecs[12] = '{32'h1234_0000, 16'h1234};
    vecs[13] = '{32'h7FFE_8000, 16'h7FFF};
    vecs[14] = '{32'h0000_0000, 16'h0000};
    vecs[15] = '{32'hC000_4000, 16'hC000};

    bus.in_valid = 1'b0;
    bus.in_data  = '0;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("reset_valid", 32'(bus.out_valid), 32'd0);
    checkOutput("reset_data", 32'(bus.out_data), 32'd0);
    checkOutput("reset_flags", 32'({bus.out_first, bus.out_last, bus.frame_err, bus.busy}), 32'd0);
    @(posedge clk); #1;
    reset = 1'b1;

    // Ramp burst: first word one cycle after last capture, 16 back-to-back words
    for (int k = 0; k < N; k++) frameWords[k] = 32'(k) << 16;
    applyStimulus(N, 1'b1);
    idleInputs();
    @(negedge clk);
    checkOutput("first_latency", 32'({bus.out_valid, bus.out_first}), 32'b11);
    repeat (N - 1) @(negedge clk);
    checkOutput("last_on_16th", 32'({bus.out_valid, bus.out_last}), 32'b11);
    @(negedge clk);
    checkOutput("post_drain_idle", 32'({bus.out_valid, bus.busy}), 32'b00);
    waitDrain("ramp");

    // Conversion table
    for (int i = 0; i < N; i++) begin
      @(posedge clk); #1;
      bus.in_valid = 1'b1;
      bus.in_data  = vecs[i].inData;
      expQ.push_back('{data: vecs[i].expOut, first: (i == 0), last: (i == N - 1)});
    end
    idleInputs();
    waitDrain("table");

    // Backpressure with random words
    readyMode = 1'b1;
    for (int k = 0; k < N; k++) frameWords[k] = $urandom();
    applyStimulus(N, 1'b1);
    idleInputs();
    waitDrain("backpressure");
    readyMode = 1'b0;
    repeat (2) @(posedge clk);

    // Short frame: 7 words then in_valid low
    errEdges = 0;
    errHigh  = 0;
    sawValid = 1'b0;
    for (int k = 0; k < N; k++) frameWords[k] = $urandom();
    applyStimulus(7, 1'b0);
    idleInputs();
    repeat (4) @(negedge clk);
    checkOutput("short_err_pulses", 32'(errEdges), 32'd1);
    checkOutput("short_err_width", 32'(errHigh), 32'd1);
    checkOutput("short_no_valid", 32'(sawValid), 32'd0);
    checkOutput("short_idle", 32'({bus.busy, bus.frame_err}), 32'b00);

    // Overrun: second burst lands entirely inside the first frame's drain
    errEdges = 0;
    for (int k = 0; k < N; k++) frameWords[k] = (32'(k) * 32'h0003_0000) + 32'h0000_4000;
    applyStimulus(N, 1'b1);
    for (int k = 0; k < N; k++) frameWords[k] = 32'h0100_0000 + (32'(k) << 16);
    applyStimulus(N, 1'b0);
    idleInputs();
    waitDrain("overrun");
    checkOutput("overrun_err_pulses", 32'(errEdges), 32'd1);
    checkOutput("overrun_idle", 32'(bus.busy), 32'd0);

    // Reset while word 5 is presented
    for (int k = 0; k < N; k++) frameWords[k] = (32'(k) * 32'h0005_0000);
    applyStimulus(N, 1'b1);
    idleInputs();
    found = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (bus.out_valid && bus.out_data == 16'd25) begin
        found = 1'b1;
        break;
      end
    end
    checks++;
    if (!found) begin
      errors++;
      $display("[TB] FAIL word5_seen: got timeout, expected out_data 0x19");
    end
    reset = 1'b0;
    @(negedge clk);
    checkOutput("midreset_valid", 32'(bus.out_valid), 32'd0);
    checkOutput("midreset_busy", 32'(bus.busy), 32'd0);
    expQ.delete();
    @(posedge clk); #1;
    reset = 1'b1;

`ifdef GSIM_SINK_CONVERGE_EN
    // Convergence: identical frames, then one word moved by 3
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    for (int k = 0; k < N; k++) frameWords[k] = (32'(k) * 32'h0007_0000) + 32'h0000_1000;
    for (int pass = 0; pass < 3; pass++) begin
      if (pass == 2) frameWords[7] = frameWords[7] + 32'h0003_0000;
      applyStimulus(N, 1'b1);
      idleInputs();
      @(negedge clk);
      checkOutput("converged", 32'(bus.converged), (pass == 1) ? 32'd1 : 32'd0);
      waitDrain("converge");
    end
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
